// File: rtl/seq_bin2bcd_pkg.sv
// Shared display codes and FSM encoding for the sequential binary-to-BCD converter.
// The display codes are consumed by the seven-segment stage as well.
package seq_bin2bcd_pkg;

  localparam logic [3:0] BCD_BLANK      = 4'hD;
  localparam logic [3:0] BCD_MINUS      = 4'hE;
  localparam logic [3:0] BCD_UNDERSCORE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_bin2bcd_add3_digit.sv
// Combinational double-dabble correction for one BCD digit: add 3 when the digit is >= 5.
module bcd_add3_digit (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/seq_bin2bcd.sv
// Sequential double-dabble converter, one magnitude bit per clock, start/busy/done handshake.
// Define SEQ_BIN2BCD_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module seq_bin2bcd
  import seq_bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  neg_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg_out
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               neg_out_q, neg_out_d;

  logic [BCD_W-1:0]   scr_q, scr_d, scr_adj, bcd_fmt;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               neg_lat_q, neg_lat_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_i (scr_q[4*g +: 4]),
      .digit_o (scr_adj[4*g +: 4])
    );
  end

`ifdef SEQ_BIN2BCD_BLANK_EN
  // Scan from the top digit down; everything above the first non-zero digit is blanked.
  function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] raw);
    logic             seen;
    logic [BCD_W-1:0] r;
    r    = raw;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (raw[4*i +: 4] != 4'd0) seen = 1'b1;
      if (!seen) r[4*i +: 4] = BCD_BLANK;
    end
    return r;
  endfunction

  assign bcd_fmt = blank_leading(scr_q);
`else
  assign bcd_fmt = scr_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    neg_out_d = neg_out_q;
    scr_d     = scr_q;
    bin_d     = bin_q;
    neg_lat_d = neg_lat_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          bin_d     = bin_in;
          neg_lat_d = neg_in & (bin_in != '0);
          scr_d     = '0;
          cnt_d     = CNT_W'(BIN_W);
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {scr_d, bin_d} = {scr_adj, bin_q} << 1;
        cnt_d          = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        // busy stays set here so it also covers the cycle in which done is visible.
        bcd_d     = bcd_fmt;
        neg_out_d = neg_lat_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      neg_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      neg_out_q <= neg_out_d;
    end
  end

  // Datapath scratch needs no reset: it is always reloaded when a conversion is accepted.
  always_ff @(posedge clk) begin
    scr_q     <= scr_d;
    bin_q     <= bin_d;
    neg_lat_q <= neg_lat_d;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign neg_out = neg_out_q;

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Directed bench for seq_bin2bcd; expectations follow the SEQ_BIN2BCD_BLANK_EN setting of the build.
module tb_seq_bin2bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin_in = '0;
  logic        neg_in = 1'b0;
  logic        busy, done, neg_out;
  logic [19:0] bcd_out;

  int n_total = 0;
  int n_bad   = 0;

  seq_bin2bcd #(.BIN_W(14), .DIGITS(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .neg_in  (neg_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .neg_out (neg_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives a one-edge start pulse; returns at the negedge of the first cycle after acceptance.
  task automatic start_conv(input logic [13:0] b, input logic n);
    @(negedge clk);
    bin_in = b;
    neg_in = n;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Counts cycles (cycle 1 = first after acceptance) until done, with a bound.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 1;
    busy_n = 0;
    while (lat < 40) begin
      if (busy) busy_n++;
      if (done) break;
      @(negedge clk);
      lat++;
    end
  endtask

  function automatic logic [19:0] fmt(input logic [19:0] raw);
    logic [19:0] r;
    r = raw;
`ifdef SEQ_BIN2BCD_BLANK_EN
    for (int i = 4; i >= 1; i--) begin
      if (r[4*i +: 4] != 4'd0) break;
      r[4*i +: 4] = 4'hD;
    end
`endif
    return r;
  endfunction

  initial begin
    int          lat, bn, dn, first_c, c2;
    logic        hold_ok;
    logic [19:0] prev;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd_out, 0);
    check("rst_neg", neg_out, 0);
    rst = 1'b1;

    // Zero with negative flag: no minus sign
    start_conv(14'd0, 1'b1);
    wait_done(lat, bn);
    check("zero_lat", lat, 16);
    check("zero_bcd", bcd_out, fmt(20'h00000));
    check("zero_neg", neg_out, 0);

    // Full-scale value and busy width
    start_conv(14'd16383, 1'b0);
    wait_done(lat, bn);
    check("max_lat", lat, 16);
    check("max_bcd", bcd_out, 20'h16383);
    check("max_neg", neg_out, 0);
    @(negedge clk);
    if (busy) bn++;
    check("max_busy_cycles", bn, 16);
    check("done_one_cycle", done, 0);

    // Negative value
    start_conv(14'd255, 1'b1);
    wait_done(lat, bn);
    check("n255_bcd", bcd_out, fmt(20'h00255));
    check("n255_neg", neg_out, 1);
    repeat (3) @(negedge clk);
    check("hold_bcd", bcd_out, fmt(20'h00255));
    check("hold_neg", neg_out, 1);

    // Start while busy is ignored; outputs never show scratch
    prev    = bcd_out;
    hold_ok = 1'b1;
    dn      = 0;
    first_c = 0;
    start_conv(14'd100, 1'b0);
    for (int c = 2; c <= 32; c++) begin
      @(negedge clk);
      if (c == 5) begin
        start  = 1'b1;
        bin_in = 14'd9999;
        neg_in = 1'b1;
      end
      if (c == 6) start = 1'b0;
      if (done) begin
        dn++;
        if (first_c == 0) first_c = c;
      end else if (dn == 0 && bcd_out !== prev) begin
        hold_ok = 1'b0;
      end
    end
    check("ign_done_count", dn, 1);
    check("ign_lat", first_c, 16);
    check("ign_no_scratch", hold_ok, 1);
    check("ign_bcd", bcd_out, fmt(20'h00100));
    check("ign_neg", neg_out, 0);

    // Reset mid-conversion aborts immediately
    start_conv(14'd1234, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_bcd", bcd_out, 0);
    check("abort_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dn  = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);
    check("abort_bcd_held", bcd_out, 0);
    start_conv(14'd42, 1'b0);
    wait_done(lat, bn);
    check("after_abort_lat", lat, 16);
    check("after_abort_bcd", bcd_out, fmt(20'h00042));

    // start held high: back-to-back conversions
    @(negedge clk);
    bin_in  = 14'd7;
    neg_in  = 1'b0;
    start   = 1'b1;
    dn      = 0;
    first_c = 0;
    c2      = 0;
    hold_ok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        if (dn == 1) first_c = c;
        if (dn == 2) c2 = c;
      end
      if (dn > 0 && bcd_out !== fmt(20'h00007)) hold_ok = 1'b0;
    end
    start = 1'b0;
    check("b2b_count", dn, 3);
    check("b2b_first", first_c, 16);
    check("b2b_period", c2 - first_c, 16);
    check("b2b_stable", hold_ok, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
